// File: rtl/ahb2sram_pkg.sv
// rtl/ahb2sram_pkg.sv - shared SRAM widths, requester id type and wen expansion
package ahb2sram_pkg;
  localparam int SRAM_DW = 32;
  localparam int BE_W    = 4;

  typedef logic req_id_t;

  // Macro write enables are per-bit and active-low; a read (we=0) yields all ones.
  function automatic logic [SRAM_DW-1:0] be_to_wen(input logic we, input logic [BE_W-1:0] be);
    logic [SRAM_DW-1:0] wen;
    for (int b = 0; b < BE_W; b++) begin
      wen[b*8 +: 8] = {8{~(we & be[b])}};
    end
    return wen;
  endfunction
endpackage

// File: rtl/sram_model.sv
// rtl/sram_model.sv - single-port bit-sliced SRAM macro with per-bit active-low wen
module SRAM_model #(
  parameter int ADDR = 9
) (
  input  logic            clk,
  input  logic            cen,
  input  logic [31:0]     wen,
  input  logic [ADDR-1:0] addr,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata
);
  logic [31:0] r_mem [0:(1<<ADDR)-1];

  always_ff @(posedge clk) begin
    if (!cen) begin
      r_mem[addr] <= (r_mem[addr] & wen) | (wdata & ~wen);
      rdata       <= r_mem[addr];
    end
  end
endmodule

// File: rtl/sram_rr_arb2.sv
// rtl/sram_rr_arb2.sv - two-way round-robin pointer and combinational grant
module sram_rr_arb2
  import ahb2sram_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    req0,
  input  logic    req1,
  output logic    gnt0,
  output logic    gnt1,
  output req_id_t win
);
  req_id_t r_last;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (req0 && req1) begin
        gnt0 = r_last;
        gnt1 = ~r_last;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  assign win = gnt1;

  // Reset to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (gnt0 || gnt1) begin
      r_last <= gnt1;
    end
  end
endmodule

// File: rtl/sram_arb2.sv
// rtl/sram_arb2.sv - two-requester SRAM arbiter, port mux and read-return pipeline
module sram_arb2
  import ahb2sram_pkg::*;
#(
  parameter int ADDR = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0,
  input  logic               req1,
  input  logic               we0,
  input  logic               we1,
  input  logic [ADDR-1:0]    addr0,
  input  logic [ADDR-1:0]    addr1,
  input  logic [BE_W-1:0]    be0,
  input  logic [BE_W-1:0]    be1,
  input  logic [SRAM_DW-1:0] wdata0,
  input  logic [SRAM_DW-1:0] wdata1,
  output logic               gnt0,
  output logic               gnt1,
  output logic               rvalid0,
  output logic               rvalid1,
  output logic [SRAM_DW-1:0] rdata0,
  output logic [SRAM_DW-1:0] rdata1,
  output logic               sram_cen,
  output logic [SRAM_DW-1:0] sram_wen,
  output logic [ADDR-1:0]    sram_addr,
  output logic [SRAM_DW-1:0] sram_wdata,
  input  logic [SRAM_DW-1:0] sram_rdata
);
  logic         w_gnt0;
  logic         w_gnt1;
  req_id_t      w_win;
  logic         w_act;
  logic         w_we;
  logic [BE_W-1:0] w_be;
  logic         w_rvalid0;
  logic         w_rvalid1;

  logic         r_rd_pend;
  req_id_t      r_rd_id;
  logic [SRAM_DW-1:0] r_hold0;
  logic [SRAM_DW-1:0] r_hold1;

  sram_rr_arb2 u_arb (
    .clk  (clk),
    .rst  (rst),
    .req0 (req0),
    .req1 (req1),
    .gnt0 (w_gnt0),
    .gnt1 (w_gnt1),
    .win  (w_win)
  );

  assign gnt0  = w_gnt0;
  assign gnt1  = w_gnt1;
  assign w_act = w_gnt0 | w_gnt1;
  assign w_we  = w_win ? we1 : we0;
  assign w_be  = w_win ? be1 : be0;

  // Idle and read cycles both collapse to an all-ones wen through the we term.
  assign sram_cen   = ~w_act;
  assign sram_addr  = w_win ? addr1 : addr0;
  assign sram_wdata = w_win ? wdata1 : wdata0;
  assign sram_wen   = be_to_wen(w_act & w_we, w_be);

  // Macro data is only valid during the rvalid cycle, so it bypasses the hold register.
  assign w_rvalid0 = r_rd_pend & ~r_rd_id & ~rst;
  assign w_rvalid1 = r_rd_pend &  r_rd_id & ~rst;
  assign rvalid0   = w_rvalid0;
  assign rvalid1   = w_rvalid1;
  assign rdata0    = rst ? '0 : (w_rvalid0 ? sram_rdata : r_hold0);
  assign rdata1    = rst ? '0 : (w_rvalid1 ? sram_rdata : r_hold1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_pend <= 1'b0;
      r_rd_id   <= 1'b0;
      r_hold0   <= '0;
      r_hold1   <= '0;
    end else begin
      r_rd_pend <= w_act & ~w_we;
      r_rd_id   <= w_win;
      if (w_rvalid0) r_hold0 <= sram_rdata;
      if (w_rvalid1) r_hold1 <= sram_rdata;
    end
  end
endmodule

// File: tb/tb_sram_arb2.sv
// tb/tb_sram_arb2.sv - self-checking bench for sram_arb2 with SRAM_model
module tb_sram_arb2;
  localparam int ADDR = 9;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req0 = 1'b0, req1 = 1'b0;
  logic            we0 = 1'b0, we1 = 1'b0;
  logic [ADDR-1:0] addr0 = '0, addr1 = '0;
  logic [3:0]      be0 = '0, be1 = '0;
  logic [31:0]     wdata0 = '0, wdata1 = '0;
  logic            gnt0, gnt1, rvalid0, rvalid1;
  logic [31:0]     rdata0, rdata1;
  logic            sram_cen;
  logic [31:0]     sram_wen, sram_wdata, sram_rdata;
  logic [ADDR-1:0] sram_addr;

  int total = 0;
  int bad   = 0;

  sram_arb2 #(.ADDR(ADDR)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .be0(be0), .be1(be1),
    .wdata0(wdata0), .wdata1(wdata1), .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata0(rdata0), .rdata1(rdata1),
    .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  SRAM_model #(.ADDR(ADDR)) u_sram (
    .clk(clk), .cen(sram_cen), .wen(sram_wen), .addr(sram_addr),
    .wdata(sram_wdata), .rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: memory image, last winner, outstanding read and per-requester held data.
  bit [31:0] m_mem [0:(1<<ADDR)-1];
  int        m_last = 1;
  bit        m_pend = 0;
  int        m_pid  = 0;
  bit [31:0] m_pdata = 0;
  bit [31:0] m_hold [2] = '{0, 0};
  int        cyc = 0;
  bit        rec = 0;
  int        gq[$];
  int        cq[$];

  always @(negedge clk) begin
    bit        eg0, eg1, act, ev0, ev1, ewe;
    int        w;
    bit [8:0]  ea;
    bit [3:0]  ebe;
    bit [31:0] ewd, ewen;
    cyc++;
    if (rst) begin
      eg0 = 0; eg1 = 0;
    end else if (req0 && req1) begin
      eg0 = (m_last == 1); eg1 = !eg0;
    end else begin
      eg0 = req0; eg1 = req1;
    end
    act = eg0 | eg1;
    w   = eg1 ? 1 : 0;
    ewe = (w == 1) ? we1 : we0;
    ea  = (w == 1) ? addr1 : addr0;
    ebe = (w == 1) ? be1 : be0;
    ewd = (w == 1) ? wdata1 : wdata0;
    ewen = 32'hFFFF_FFFF;
    if (act && ewe)
      for (int b = 0; b < 4; b++) if (ebe[b]) ewen[8*b +: 8] = 8'h00;
    ev0 = !rst && m_pend && (m_pid == 0);
    ev1 = !rst && m_pend && (m_pid == 1);

    chk("gnt0", 32'(gnt0), 32'(eg0));
    chk("gnt1", 32'(gnt1), 32'(eg1));
    chk("sram_cen", 32'(sram_cen), 32'(!act));
    chk("sram_wen", sram_wen, ewen);
    if (act) begin
      chk("sram_addr", 32'(sram_addr), 32'(ea));
      chk("sram_wdata", sram_wdata, ewd);
    end
    chk("rvalid0", 32'(rvalid0), 32'(ev0));
    chk("rvalid1", 32'(rvalid1), 32'(ev1));
    chk("rdata0", rdata0, rst ? 32'h0 : (ev0 ? m_pdata : m_hold[0]));
    chk("rdata1", rdata1, rst ? 32'h0 : (ev1 ? m_pdata : m_hold[1]));
    if (rec && act) begin
      gq.push_back(w);
      cq.push_back(cyc);
    end

    if (rst) begin
      m_last = 1;
      m_pend = 0;
      m_hold = '{0, 0};
    end else begin
      if (ev0) m_hold[0] = m_pdata;
      if (ev1) m_hold[1] = m_pdata;
      m_pend = 0;
      if (act) begin
        m_last = w;
        if (ewe) begin
          for (int b = 0; b < 4; b++) if (ebe[b]) m_mem[ea][8*b +: 8] = ewd[8*b +: 8];
        end else begin
          m_pend  = 1;
          m_pid   = w;
          m_pdata = m_mem[ea];
        end
      end
    end
  end

  // Raise a request, hold it until granted, drop it just after the accepting edge.
  task automatic do_acc(input int r, input bit w, input logic [8:0] a,
                        input logic [3:0] b, input logic [31:0] d);
    int n = 0;
    bit g;
    if (r == 0) begin we0 = w; addr0 = a; be0 = b; wdata0 = d; req0 = 1'b1; end
    else        begin we1 = w; addr1 = a; be1 = b; wdata1 = d; req1 = 1'b1; end
    do begin
      @(negedge clk);
      n++;
      g = (r == 0) ? gnt0 : gnt1;
    end while (!g && n < 20);
    if (!g) begin
      total++; bad++;
      $display("FAIL grant_timeout: requester %0d got no grant want grant within 20 cycles", r);
    end
    @(posedge clk); #1;
    if (r == 0) req0 = 1'b0; else req1 = 1'b0;
  endtask

  task automatic next_cyc();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset with both requesting writes.
    req0 = 1; we0 = 1; addr0 = 9'd3; be0 = 4'hF; wdata0 = 32'h0102_0304;
    req1 = 1; we1 = 1; addr1 = 9'd4; be1 = 4'hF; wdata1 = 32'h0506_0708;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", {30'd0, gnt1, gnt0}, 32'h0);
    chk("rst_cen", 32'(sram_cen), 32'h1);
    chk("rst_wen", sram_wen, 32'hFFFF_FFFF);
    chk("rst_rvalid", {30'd0, rvalid1, rvalid0}, 32'h0);
    chk("rst_rdata0", rdata0, 32'h0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("first_gnt", {30'd0, gnt1, gnt0}, 32'h1);
    next_cyc();
    req0 = 0;
    @(negedge clk);
    chk("second_gnt", {30'd0, gnt1, gnt0}, 32'h2);
    next_cyc();
    req1 = 0;

    // Single write then read.
    do_acc(0, 1, 9'd5, 4'hF, 32'hDEAD_BEEF);
    do_acc(0, 0, 9'd5, 4'h0, 32'h0);
    @(negedge clk);
    chk("single_rvalid0", 32'(rvalid0), 32'h1);
    chk("single_rdata0", rdata0, 32'hDEAD_BEEF);
    chk("single_rvalid1", 32'(rvalid1), 32'h0);
    next_cyc();

    // Byte enables, including an all-zero mask.
    do_acc(0, 1, 9'd7, 4'hF, 32'h1122_3344);
    do_acc(0, 1, 9'd7, 4'b0101, 32'hAABB_CCDD);
    do_acc(0, 0, 9'd7, 4'h0, 32'h0);
    @(negedge clk);
    chk("be_rdata0", rdata0, 32'h11BB_33DD);
    chk("be_model", m_mem[7], 32'h11BB_33DD);
    next_cyc();
    do_acc(0, 1, 9'd7, 4'h0, 32'hFFFF_FFFF);
    do_acc(0, 0, 9'd7, 4'h0, 32'h0);
    @(negedge clk);
    chk("be0_rdata0", rdata0, 32'h11BB_33DD);
    next_cyc();

    // Contention: six reads from each requester.
    for (int i = 0; i < 12; i++) do_acc(1, 1, 9'(20 + i), 4'hF, 32'hC0DE_0000 + 32'(i));
    rec = 1;
    fork
      for (int i = 0; i < 6; i++) do_acc(0, 0, 9'(20 + i), 4'h0, 32'h0);
      for (int i = 0; i < 6; i++) do_acc(1, 0, 9'(26 + i), 4'h0, 32'h0);
    join
    rec = 0;
    @(negedge clk);
    chk("cont_last_rvalid1", 32'(rvalid1), 32'h1);
    chk("cont_last_rdata1", rdata1, 32'hC0DE_000B);
    chk("cont_rdata0_held", rdata0, 32'hC0DE_0005);
    chk("cont_count", 32'(gq.size()), 32'd12);
    for (int i = 0; i < gq.size() && i < 12; i++) begin
      chk("cont_order", 32'(gq[i]), 32'(i % 2));
      chk("cont_cycle", 32'(cq[i] - cq[0]), 32'(i));
    end
    next_cyc();

    // Write by req1, read of the same word by req0 on the next cycle.
    do_acc(1, 1, 9'd9, 4'hF, 32'h5A5A_5A5A);
    do_acc(0, 0, 9'd9, 4'h0, 32'h0);
    @(negedge clk);
    chk("hazard_rvalid0", 32'(rvalid0), 32'h1);
    chk("hazard_rdata0", rdata0, 32'h5A5A_5A5A);
    next_cyc();

    // Reset arriving one cycle after a read grant.
    do_acc(0, 1, 9'd40, 4'hF, 32'h0BAD_F00D);
    we0 = 0; addr0 = 9'd40; be0 = 4'h0; req0 = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!gnt0 && n < 20);
    chk("rstrd_grant", 32'(gnt0), 32'h1);
    @(posedge clk); #1;
    req0 = 0;
    rst  = 1;
    @(negedge clk);
    chk("rstrd_rvalid0", 32'(rvalid0), 32'h0);
    chk("rstrd_rdata0", rdata0, 32'h0);
    next_cyc();
    next_cyc();
    rst = 0;
    do_acc(0, 0, 9'd40, 4'h0, 32'h0);
    @(negedge clk);
    chk("reissue_rdata0", rdata0, 32'h0BAD_F00D);
    next_cyc();
    repeat (2) next_cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
